// File: rtl/bypass_skid_buffer_if.sv
// Valid/ready handshake bundle between a producer, the skid buffer and a consumer.
// The slave modport is the buffer's view. The master modport is the surrounding logic's view.
interface bypass_skid_buffer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] Input_Data;
  logic                  Input_Valid;
  logic                  Input_Ready;
  logic [DATA_WIDTH-1:0] Output_Data;
  logic                  Output_Valid;
  logic                  Output_Ready;
  logic [1:0]            Occupancy;

  modport slave (
    input  Input_Data,
    input  Input_Valid,
    output Input_Ready,
    output Output_Data,
    output Output_Valid,
    input  Output_Ready,
    output Occupancy
  );

  modport master (
    output Input_Data,
    output Input_Valid,
    input  Input_Ready,
    input  Output_Data,
    input  Output_Valid,
    output Output_Ready,
    input  Occupancy
  );
endinterface

// File: rtl/bypass_skid_buffer.sv
// Two-entry registered skid buffer: every output decodes from flops only,
// so neither valid nor ready has a combinational path through the block.
module bypass_skid_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  bypass_skid_buffer_if.slave    bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  live_q;
  logic                  in_fire;
  logic                  out_fire;

  // live_q keeps Input_Ready low until the first edge after reset release.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      live_q  <= 1'b1;
    end
  end

  assign bus.Input_Ready  = live_q && (state_q != FULL);
  assign bus.Output_Valid = (state_q != EMPTY);
  assign bus.Output_Data  = main_q;

  assign in_fire  = bus.Input_Valid && bus.Input_Ready;
  assign out_fire = bus.Output_Valid && bus.Output_Ready;

  always_comb begin
    bus.Occupancy = 2'd0;
    case (state_q)
      BUSY:    bus.Occupancy = 2'd1;
      FULL:    bus.Occupancy = 2'd2;
      default: bus.Occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = bus.Input_Data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = bus.Input_Data;
        end else if (in_fire) begin
          // Consumer stalled while a word arrived: park it behind main.
          skid_d  = bus.Input_Data;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_bypass_skid_buffer.sv
// Self-checking bench for bypass_skid_buffer: directed scenarios plus a random
// stall run, all compared against a queue-based model of a 2-deep FIFO.
module tb_bypass_skid_buffer;

  logic CLK;
  logic RST_n;
  int   checks;
  int   errors;

  bypass_skid_buffer_if #(.DATA_WIDTH(8)) bus ();

  bypass_skid_buffer #(.DATA_WIDTH(8)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: a FIFO of capacity 2 plus the last word that left it.
  logic [7:0] mq[$];
  logic [7:0] m_last;
  bit         m_live;
  bit         m_in_fire;
  bit         m_out_fire;

  function automatic logic [7:0] m_data();
    return (mq.size() > 0) ? mq[0] : m_last;
  endfunction

  function automatic logic m_ready();
    return m_live && (mq.size() < 2);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last = 8'h00;
    m_live = 1'b0;
  endtask

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    @(posedge CLK);
    m_in_fire  = 1'b0;
    m_out_fire = 1'b0;
    if (RST_n) begin
      if (!m_live) begin
        m_live = 1'b1;
      end else begin
        m_out_fire = (mq.size() > 0) && bus.Output_Ready;
        m_in_fire  = bus.Input_Valid && (mq.size() < 2);
        if (m_out_fire) m_last = mq.pop_front();
        if (m_in_fire)  mq.push_back(bus.Input_Data);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    RST_n            = 1'b0;
    bus.Input_Valid  = 1'b1;
    bus.Input_Data   = 8'hAA;
    bus.Output_Ready = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.Output_Valid !== 1'b0 || bus.Output_Data !== 8'h00 || bus.Input_Ready !== 1'b0 || bus.Occupancy !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: valid=%b data=%h ready=%b occ=%0d required 0/00/0/0", i, bus.Output_Valid, bus.Output_Data, bus.Input_Ready, bus.Occupancy);
      end
      tick();
    end
    RST_n = 1'b1;
    #1;
    checks++;
    if (bus.Input_Ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 0", bus.Input_Ready);
    end
    tick();
    checks++;
    if (bus.Input_Ready !== 1'b1 || bus.Output_Valid !== 1'b0 || bus.Output_Data !== 8'h00) begin
      errors++;
      $display("FAIL reset_first_edge: ready=%b valid=%b data=%h required 1/0/00", bus.Input_Ready, bus.Output_Valid, bus.Output_Data);
    end
    bus.Input_Valid = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    bus.Output_Ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.Input_Valid = 1'b1;
      bus.Input_Data  = 8'(i);
      tick();
      checks++;
      if (bus.Output_Valid !== 1'b1 || bus.Output_Data !== 8'(i) || bus.Occupancy !== 2'd1 || bus.Input_Ready !== 1'b1) begin
        errors++;
        $display("FAIL stream word %0d: valid=%b data=%h occ=%0d ready=%b required 1/%h/1/1", i, bus.Output_Valid, bus.Output_Data, bus.Occupancy, bus.Input_Ready, 8'(i));
      end
    end
    bus.Input_Valid = 1'b0;
    tick();
    checks++;
    if (bus.Output_Valid !== 1'b0 || bus.Occupancy !== 2'd0 || bus.Output_Data !== 8'h10) begin
      errors++;
      $display("FAIL stream_empty: valid=%b occ=%0d data=%h required 0/0/10", bus.Output_Valid, bus.Occupancy, bus.Output_Data);
    end
  endtask

  task automatic test_skid_fill();
    logic [7:0] words [3];
    logic [1:0] exp_occ [3];
    logic       exp_rdy [3];
    words   = '{8'h11, 8'h22, 8'h33};
    exp_occ = '{2'd1, 2'd2, 2'd2};
    exp_rdy = '{1'b1, 1'b0, 1'b0};
    bus.Output_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.Input_Valid = 1'b1;
      bus.Input_Data  = words[i];
      tick();
      checks++;
      if (bus.Occupancy !== exp_occ[i] || bus.Input_Ready !== exp_rdy[i] || bus.Output_Data !== 8'h11 || bus.Output_Valid !== 1'b1) begin
        errors++;
        $display("FAIL skid_fill step %0d: occ=%0d ready=%b data=%h valid=%b required %0d/%b/11/1", i, bus.Occupancy, bus.Input_Ready, bus.Output_Data, bus.Output_Valid, exp_occ[i], exp_rdy[i]);
      end
    end
  endtask

  task automatic test_drain();
    bus.Output_Ready = 1'b1;
    bus.Input_Valid  = 1'b1;
    bus.Input_Data   = 8'h33;
    tick();
    checks++;
    if (bus.Output_Data !== 8'h22 || bus.Occupancy !== 2'd1 || bus.Input_Ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_first: data=%h occ=%0d ready=%b required 22/1/1", bus.Output_Data, bus.Occupancy, bus.Input_Ready);
    end
    bus.Input_Valid = 1'b0;
    tick();
    checks++;
    if (bus.Output_Valid !== 1'b0 || bus.Occupancy !== 2'd0) begin
      errors++;
      $display("FAIL drain_second: valid=%b occ=%0d required 0/0", bus.Output_Valid, bus.Occupancy);
    end
    bus.Input_Valid = 1'b1;
    bus.Input_Data  = 8'h33;
    tick();
    bus.Input_Valid = 1'b0;
    checks++;
    if (bus.Output_Valid !== 1'b1 || bus.Output_Data !== 8'h33 || bus.Occupancy !== 2'd1) begin
      errors++;
      $display("FAIL drain_late_word: valid=%b data=%h occ=%0d required 1/33/1", bus.Output_Valid, bus.Output_Data, bus.Occupancy);
    end
    tick();
  endtask

  task automatic test_random_stall();
    int         sent;
    int         recvd;
    int         cyc;
    bit         prev_stall;
    logic [7:0] prev_data;
    sent       = 0;
    recvd      = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    while ((recvd < 1000) && (cyc < 20000)) begin
      bus.Input_Valid  = (sent < 1000) && ($urandom_range(3) != 0);
      bus.Input_Data   = 8'(sent);
      bus.Output_Ready = ($urandom_range(2) != 0);
      #1;
      checks++;
      if (bus.Output_Valid !== (mq.size() > 0) || bus.Input_Ready !== m_ready() || bus.Occupancy !== 2'(mq.size()) || bus.Output_Data !== m_data()) begin
        errors++;
        $display("FAIL random_state cyc %0d: valid=%b ready=%b occ=%0d data=%h required %b/%b/%0d/%h", cyc, bus.Output_Valid, bus.Input_Ready, bus.Occupancy, bus.Output_Data, (mq.size() > 0), m_ready(), mq.size(), m_data());
      end
      if (prev_stall) begin
        checks++;
        if (bus.Output_Data !== prev_data) begin
          errors++;
          $display("FAIL random_stable cyc %0d: data=%h required %h", cyc, bus.Output_Data, prev_data);
        end
      end
      if (bus.Output_Valid === 1'b1 && bus.Output_Ready) begin
        checks++;
        if (bus.Output_Data !== 8'(recvd)) begin
          errors++;
          $display("FAIL random_order word %0d: data=%h required %h", recvd, bus.Output_Data, 8'(recvd));
        end
        recvd++;
      end
      prev_stall = (bus.Output_Valid === 1'b1) && !bus.Output_Ready;
      prev_data  = bus.Output_Data;
      tick();
      if (m_in_fire) sent++;
      cyc++;
    end
    checks++;
    if (recvd != 1000) begin
      errors++;
      $display("FAIL random_timeout: received %0d words required 1000", recvd);
    end
    bus.Input_Valid  = 1'b0;
    bus.Output_Ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_mid_reset();
    bus.Output_Ready = 1'b0;
    bus.Input_Valid  = 1'b1;
    bus.Input_Data   = 8'h44;
    tick();
    bus.Input_Data   = 8'h55;
    tick();
    bus.Input_Valid  = 1'b0;
    checks++;
    if (bus.Occupancy !== 2'd2 || bus.Output_Data !== 8'h44) begin
      errors++;
      $display("FAIL midrst_setup: occ=%0d data=%h required 2/44", bus.Occupancy, bus.Output_Data);
    end
    #2;
    RST_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.Output_Valid !== 1'b0 || bus.Output_Data !== 8'h00 || bus.Input_Ready !== 1'b0 || bus.Occupancy !== 2'd0) begin
      errors++;
      $display("FAIL midrst_async: valid=%b data=%h ready=%b occ=%0d required 0/00/0/0", bus.Output_Valid, bus.Output_Data, bus.Input_Ready, bus.Occupancy);
    end
    tick();
    #2;
    RST_n = 1'b1;
    bus.Output_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.Output_Valid !== 1'b0 || bus.Output_Data === 8'h44 || bus.Output_Data === 8'h55) begin
        errors++;
        $display("FAIL midrst_ghost cyc %0d: valid=%b data=%h required 0 and no 44/55", i, bus.Output_Valid, bus.Output_Data);
      end
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    RST_n            = 1'b0;
    bus.Input_Valid  = 1'b0;
    bus.Input_Data   = 8'h00;
    bus.Output_Ready = 1'b0;
    test_reset();
    test_streaming();
    test_skid_fill();
    test_drain();
    test_random_stall();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bypass_skid_buffer.md
Name: bypass_skid_buffer

Overview:
- Registered counterpart to the combinational input-to-output bypass: carries Input_Data to Output_Data through a 2-entry skid buffer with valid/ready handshakes on both sides.
- Breaks the timing path between producer and consumer, including the backpressure path, while sustaining one word per clock.
- Sits between any two blocks exchanging DATA_WIDTH-bit words.

Parameters:
- DATA_WIDTH, 8, width of Input_Data and Output_Data.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_n  input  1  asynchronous active-low reset.
- Input_Data  input  DATA_WIDTH  word from producer.
- Input_Valid  input  1  producer offers Input_Data this cycle.
- Input_Ready  output  1  buffer accepts a word this cycle.
- Output_Data  output  DATA_WIDTH  word to consumer; comes straight from the main register.
- Output_Valid  output  1  Output_Data holds a valid word.
- Output_Ready  input  1  consumer takes Output_Data this cycle.
- Occupancy  output  2  words held: 0, 1 or 2.

Behaviour:
- Interface (already decided): one clock, CLK; reset RST_n is asynchronous and active-low.
- Reset (RST_n low, asynchronous):
  - State EMPTY; main and skid registers cleared to 0.
  - Output_Data=0, Output_Valid=0, Occupancy=0.
  - Input_Ready=0 while RST_n low; Input_Ready=1 from the first edge after release.
- Handshake events:
  - in_fire = Input_Valid & Input_Ready.
  - out_fire = Output_Valid & Output_Ready.
  - A word transfers only on a fire. Data is ignored when valid is low.
- Output decode:
  - Input_Ready, Output_Valid and Occupancy decode from the state register only.
  - No combinational path from Output_Ready or Input_Valid to any output.
  - Input_Ready = (state != FULL). Output_Valid = (state != EMPTY).
  - Occupancy: EMPTY=0, BUSY=1, FULL=2.
- States and transitions (evaluated at the rising CLK edge):
  - EMPTY:
    - in_fire: main<=Input_Data, go to BUSY.
    - Otherwise: stay.
  - BUSY:
    - in_fire & out_fire: main<=Input_Data, stay BUSY.
    - in_fire only: skid<=Input_Data, go to FULL.
    - out_fire only: go to EMPTY.
    - Neither: hold.
  - FULL (Input_Ready=0, so in_fire is impossible):
    - out_fire: main<=skid, go to BUSY.
    - Otherwise: hold main and skid.
- Latency: a word accepted at edge N is on Output_Data with Output_Valid=1 after edge N, i.e. 1 cycle.
- Throughput: 1 word/clock whenever Output_Ready is held high.
- Ordering: strict FIFO order; no word dropped or duplicated.
- Stability: while Output_Valid=1 and Output_Ready=0, Output_Data holds constant.
- Content on empty: in EMPTY, Output_Data keeps the last word (or 0 after reset); consumers must qualify it with Output_Valid.
- Backpressure reaction: Output_Ready falling while BUSY with an input arriving parks the word in skid. Input_Ready drops one cycle later, and that cycle's input is still absorbed.
- Reset mid-operation: both held words are discarded immediately; every output returns to its reset value without waiting for a clock.

Test Plan:
- Reset release: RST_n low for 3 cycles with Input_Valid=1, Input_Data=0xAA -> Output_Valid=0, Output_Data=0x00, Input_Ready=0 throughout; Input_Ready=1 after the first edge following release.
- Streaming: Output_Ready=1; send 0x01..0x10 on consecutive cycles -> Output_Data shows 0x01..0x10 one cycle later, no gaps; Occupancy stays 1.
- Skid fill: Output_Ready=0; send 0x11, 0x22 -> Occupancy 1 then 2; Input_Ready=0; Output_Data=0x11 stable; 0x33 offered next is not accepted.
- Drain from FULL: from the previous case, raise Output_Ready for 2 cycles -> 0x11 then 0x22 delivered; Occupancy 2->1->0; Input_Ready=1 after the first edge; 0x33 then accepted and delivered after 0x22.
- Random stall: random Input_Valid/Output_Ready over 1000 words with incrementing data -> output sequence identical to input; Output_Data never changes while Output_Valid=1 and Output_Ready=0.
- Mid-operation reset: in FULL holding 0x44/0x55, pulse RST_n low between edges -> Output_Valid=0 and Output_Data=0x00 immediately; 0x44 and 0x55 never appear after release.
